// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// master: controller (drives selects/strobes, sees op/funct3/zero/mem_ready); slave: datapath.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [3:0] state;
    logic       trap;

    modport master (
        input  op, funct3, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
        output alu_src_a, alu_src_b, reg_write, alu_op, state, trap
    );

    modport slave (
        output op, funct3, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
        input  alu_src_a, alu_src_b, reg_write, alu_op, state, trap
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core (fetch/decode/lw/sw/R/I/beq/bne/jal, sticky TRAP).
// Ports: clk, reset (sync, active-high), ctl (master modport), cycle_count/instret with MC_PERF_CNT_EN.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef MC_PERF_CNT_EN
    output logic [CNT_W-1:0]          cycle_count,
    output logic [CNT_W-1:0]          instret,
`endif
    multicycle_controller_if.master   ctl
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            unique case (state_q)
                FETCH:    state_q <= ctl.mem_ready ? DECODE : FETCH;
                DECODE: begin
                    unique case (ctl.op)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_R:         state_q <= EXECR;
                        OP_I:         state_q <= EXECI;
                        OP_BR:        state_q <= BRANCH;
                        OP_JAL:       state_q <= JAL;
                        default:      state_q <= TRAP;
                    endcase
                end
                MEMADR:   state_q <= ctl.op[5] ? MEMWRITE : MEMREAD;
                MEMREAD:  state_q <= ctl.mem_ready ? MEMWB : MEMREAD;
                MEMWB:    state_q <= FETCH;
                MEMWRITE: state_q <= ctl.mem_ready ? FETCH : MEMWRITE;
                EXECR:    state_q <= ALUWB;
                EXECI:    state_q <= ALUWB;
                ALUWB:    state_q <= FETCH;
                BRANCH:   state_q <= FETCH;
                JAL:      state_q <= ALUWB;
                TRAP:     state_q <= TRAP;
                default:  state_q <= FETCH;
            endcase
        end
    end

    logic       pc_w;
    logic       ir_w;
    logic       mem_w;
    logic       reg_w;
    logic       br_take;

    // Only beq/bne are decoded; other funct3 values never redirect.
    always_comb begin
        br_take = 1'b0;
        if (ctl.funct3 == 3'b000) begin
            br_take = ctl.zero;
        end else if (ctl.funct3 == 3'b001) begin
            br_take = ~ctl.zero;
        end
    end

    always_comb begin
        pc_w           = 1'b0;
        ir_w           = 1'b0;
        mem_w          = 1'b0;
        reg_w          = 1'b0;
        ctl.adr_src    = 1'b0;
        ctl.result_src = 2'b00;
        ctl.alu_src_a  = 2'b00;
        ctl.alu_src_b  = 2'b00;
        ctl.alu_op     = 2'b00;
        ctl.trap       = 1'b0;
        unique case (state_q)
            FETCH: begin
                ctl.alu_src_b  = 2'b10;
                ctl.result_src = 2'b10;
                ir_w           = ctl.mem_ready;
                pc_w           = ctl.mem_ready;
            end
            DECODE: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b01;
            end
            MEMADR: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = 2'b01;
            end
            MEMREAD: begin
                ctl.adr_src = 1'b1;
            end
            MEMWB: begin
                ctl.result_src = 2'b01;
                reg_w          = 1'b1;
            end
            MEMWRITE: begin
                ctl.adr_src = 1'b1;
                mem_w       = 1'b1;
            end
            EXECR: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_op    = 2'b10;
            end
            EXECI: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = 2'b01;
                ctl.alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_w = 1'b1;
            end
            BRANCH: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_op    = 2'b01;
                pc_w          = br_take;
            end
            JAL: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b10;
                pc_w          = 1'b1;
            end
            TRAP: begin
                ctl.trap = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Architectural strobes are suppressed for the whole reset cycle,
    // including a store that is aborted mid-wait.
    assign ctl.pc_write  = pc_w & ~reset;
    assign ctl.ir_write  = ir_w & ~reset;
    assign ctl.mem_write = mem_w & ~reset;
    assign ctl.reg_write = reg_w & ~reset;
    assign ctl.state     = state_q;

`ifdef MC_PERF_CNT_EN
    logic retire;

    // States whose successor is FETCH complete an instruction.
    always_comb begin
        retire = 1'b0;
        unique case (state_q)
            MEMWB, ALUWB, BRANCH: retire = 1'b1;
            MEMWRITE:             retire = ctl.mem_ready;
            default:              retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            instret     <= '0;
        end else begin
            if (state_q != TRAP) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (retire) begin
                instret <= instret + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Each cycle it drives the mux selects, write strobes and the 2-bit ALUOp consumed by the ALU decoder.
- It handles fetch, decode, and execution of lw/sw/R-type/I-type ALU/beq/bne/jal, with a simple memory-ready handshake.
- Illegal opcodes park the FSM in a sticky TRAP state.

Parameters:
- CNT_W, 32, width of performance counters (used only with MC_PERF_CNT_EN).

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; returns FSM to FETCH
- op  input  7  instruction opcode from IR
- funct3  input  3  IR funct3, used for branch sense
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completed the current read/write this cycle
- pc_write  output  1  load PC from result bus
- adr_src  output  1  0 = PC, 1 = ALUOut drives memory address
- mem_write  output  1  memory write strobe
- ir_write  output  1  load IR and OldPC
- result_src  output  2  00 = ALUOut, 01 = read data, 10 = ALU result
- alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  output  2  00 = rs2, 01 = imm, 10 = constant 4
- reg_write  output  1  register file write enable
- alu_op  output  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- state  output  4  current state encoding (debug)
- trap  output  1  high while in TRAP

Behaviour:
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
  - EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, TRAP = 11
  - Codes 12–15 are unreachable; they go to FETCH on the next edge.
- Reset:
  - reset high at an edge: state becomes FETCH, from any state including mid-memory-wait.
  - While reset is high, pc_write, ir_write, mem_write and reg_write are forced to 0.
  - After reset: state = 0, trap = 0.
- Outputs are decoded from state (Moore). The only exception is pc_write in BRANCH, which also depends on zero.
- Every signal not listed for a state is 0.
- FETCH:
  - adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE:
  - alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other -> TRAP
- MEMADR:
  - alu_src_a = 10, alu_src_b = 01, alu_op = 00.
  - Goes to MEMREAD if op[5] = 0, else MEMWRITE.
- MEMREAD:
  - adr_src = 1, result_src = 00.
  - Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src = 01, reg_write = 1; goes to FETCH.
- MEMWRITE:
  - adr_src = 1, result_src = 00, mem_write = 1.
  - mem_write stays asserted every cycle until mem_ready, then goes to FETCH.
- EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10; goes to ALUWB.
- EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10; goes to ALUWB.
- ALUWB: result_src = 00, reg_write = 1; goes to FETCH.
- BRANCH:
  - alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00.
  - pc_write = (funct3 == 000) ? zero : (funct3 == 001) ? ~zero : 0.
  - Goes to FETCH.
- JAL:
  - alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_write = 1.
  - Goes to ALUWB, which writes PC+4 to rd.
- TRAP: trap = 1, all strobes 0; stays in TRAP until reset.
- Latencies with mem_ready tied high:
  - lw = 5 cycles
  - sw, R-type, I-type, jal = 4 cycles
  - beq/bne = 3 cycles
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined, add outputs cycle_count[CNT_W-1:0] and instret[CNT_W-1:0]. Both clear to 0 on reset.
- cycle_count increments every non-reset cycle outside TRAP.
- instret increments on each cycle where the next state is FETCH and the current state is MEMWB, MEMWRITE (with mem_ready), ALUWB or BRANCH.
- Both counters wrap modulo 2^CNT_W.
- When undefined, these ports and their logic are absent.

Test Plan:
- reset held 2 cycles, then released with mem_ready = 1 -> state = 0, trap = 0, and no strobes during reset; first cycle: ir_write = pc_write = 1, alu_src_b = 10.
- R-type op = 0110011, mem_ready = 1 -> states 0, 1, 6, 8, 0; alu_op = 10 in EXECR; reg_write = 1 only in ALUWB.
- lw op = 0000011, mem_ready low for 2 cycles in MEMREAD -> states 0, 1, 2, 3, 3, 3, 4, 0; adr_src = 1 in MEMREAD; result_src = 01 with reg_write in MEMWB.
- Branches:
  - beq funct3 = 000, zero = 1 -> pc_write = 1 in BRANCH.
  - bne funct3 = 001, zero = 1 -> pc_write = 0.
  - In both cases alu_op = 01.
- Illegal op = 1111111 -> TRAP (state = 11, trap = 1) holds for 10 cycles with all strobes 0; reset returns state to 0.
- sw with mem_ready low, then reset asserted mid-MEMWRITE -> mem_write = 0 in the reset cycle; state = 0 next; with MC_PERF_CNT_EN, instret is unchanged by the aborted store and cleared to 0 by the reset.
